// File: rtl/tag_alloc_ctrl.sv
// Free-tag FIFO controller: seeds the FIFO with every tag after reset, grants tags round-robin
// to dispatch requesters, and funnels up to two returned tags per cycle through a 4-entry buffer.
module tag_alloc_ctrl #(
  parameter int TAGW  = 5,
  parameter int NTAGS = 32,
  parameter int NREQ  = 2
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [TAGW-1:0] gnt_tag,
  input  logic [1:0]      ret_vld,
  input  logic [TAGW-1:0] ret_tag0,
  input  logic [TAGW-1:0] ret_tag1,
  output logic            ret_rdy,
  output logic [TAGW-1:0] fifo_wdata,
  output logic            fifo_winc,
  output logic            fifo_rinc,
  input  logic [TAGW-1:0] fifo_rdata,
  input  logic            fifo_wfull,
  input  logic            fifo_rempty,
  output logic            init_done,
  output logic [TAGW:0]   free_cnt,
  output logic            err_ovf
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state_reg;
  logic [TAGW-1:0] seed_cnt_reg;
  logic [RRW-1:0]  rr_ptr_reg;
  logic [1:0]      rbuf_head_reg;
  logic [2:0]      rbuf_cnt_reg;
  logic [TAGW:0]   free_cnt_reg;
  logic            init_done_reg;
  logic            err_ovf_reg;
  logic [TAGW-1:0] rbuf_mem [4];

  logic            run;
  logic            found;
  logic [RRW-1:0]  gnt_idx;
  logic [RRW-1:0]  rr_ptr_next;
  logic            alloc_en;
  int              cand;

  // Round-robin search: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = RRW'(cand);
      end
    end
  end

  assign run         = (state_reg == ST_RUN);
  assign alloc_en    = run && !fifo_rempty && found;
  assign rr_ptr_next = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + RRW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt[gi] = alloc_en && (gnt_idx == RRW'(gi));
    end
  endgenerate

  assign gnt_tag   = fifo_rdata;
  assign fifo_rinc = alloc_en;

  // Return buffer: accept both ports only while at least two slots are guaranteed free.
  logic       acc0, acc1;
  logic       enq0, enq1;
  logic       rbuf_pop;
  logic       ovf_enq;
  logic [2:0] cnt_after_pop;
  logic [2:0] space;
  logic [1:0] slot0, slot1;

  assign ret_rdy       = run && (rbuf_cnt_reg <= 3'd2);
  assign acc0          = ret_rdy && ret_vld[0];
  assign acc1          = ret_rdy && ret_vld[1];
  assign rbuf_pop      = run && (rbuf_cnt_reg != 3'd0) && !fifo_wfull;
  assign cnt_after_pop = rbuf_cnt_reg - {2'b00, rbuf_pop};
  assign space         = 3'd4 - cnt_after_pop;
  assign enq0          = acc0 && (space != 3'd0);
  assign enq1          = acc1 && (space > {2'b00, enq0});
  assign ovf_enq       = (acc0 && !enq0) || (acc1 && !enq1);
  assign slot0         = rbuf_head_reg + rbuf_cnt_reg[1:0];
  assign slot1         = slot0 + {1'b0, enq0};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_rbuf
      always_ff @(posedge wclk) begin
        if (enq0 && (slot0 == 2'(gi)))
          rbuf_mem[gi] <= ret_tag0;
        else if (enq1 && (slot1 == 2'(gi)))
          rbuf_mem[gi] <= ret_tag1;
      end
    end
  endgenerate

  // Seeding writes are gated by wrst_n so the FIFO sees no strobe while reset is held.
  assign fifo_winc  = (wrst_n && (state_reg == ST_INIT)) || rbuf_pop;
  assign fifo_wdata = (state_reg == ST_INIT) ? seed_cnt_reg : rbuf_mem[rbuf_head_reg];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg     <= ST_INIT;
      seed_cnt_reg  <= '0;
      rr_ptr_reg    <= '0;
      rbuf_head_reg <= '0;
      rbuf_cnt_reg  <= '0;
      free_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
      err_ovf_reg   <= 1'b0;
    end else begin
      free_cnt_reg <= free_cnt_reg + (TAGW+1)'(fifo_winc) - (TAGW+1)'(fifo_rinc);
      case (state_reg)
        ST_INIT: begin
          seed_cnt_reg <= seed_cnt_reg + TAGW'(1);
          if (seed_cnt_reg == TAGW'(NTAGS - 1)) begin
            state_reg     <= ST_RUN;
            init_done_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (alloc_en) rr_ptr_reg <= rr_ptr_next;
          rbuf_head_reg <= rbuf_head_reg + {1'b0, rbuf_pop};
          rbuf_cnt_reg  <= cnt_after_pop + {2'b00, enq0} + {2'b00, enq1};
        end
        default: state_reg <= ST_INIT;
      endcase
      // A full FIFO with tags still waiting means a tag was returned twice.
      if (((ret_vld != 2'b00) && !ret_rdy) || ovf_enq ||
          (run && (rbuf_cnt_reg != 3'd0) && fifo_wfull))
        err_ovf_reg <= 1'b1;
    end
  end

  assign init_done = init_done_reg;
  assign free_cnt  = free_cnt_reg;
  assign err_ovf   = err_ovf_reg;

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Directed bench for tag_alloc_ctrl with a behavioural 32-deep show-ahead FIFO attached.
module tb_tag_alloc_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [4:0] gnt_tag;
  logic [1:0] ret_vld;
  logic [4:0] ret_tag0, ret_tag1;
  logic       ret_rdy;
  logic [4:0] fifo_wdata;
  logic       fifo_winc, fifo_rinc;
  logic [4:0] fifo_rdata;
  logic       fifo_wfull, fifo_rempty;
  logic       init_done;
  logic [5:0] free_cnt;
  logic       err_ovf;

  int total = 0;
  int bad   = 0;

  always #5 wclk = ~wclk;

  tag_alloc_ctrl #(.TAGW(5), .NTAGS(32), .NREQ(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .gnt(gnt), .gnt_tag(gnt_tag),
    .ret_vld(ret_vld), .ret_tag0(ret_tag0), .ret_tag1(ret_tag1), .ret_rdy(ret_rdy),
    .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc), .fifo_rinc(fifo_rinc),
    .fifo_rdata(fifo_rdata), .fifo_wfull(fifo_wfull), .fifo_rempty(fifo_rempty),
    .init_done(init_done), .free_cnt(free_cnt), .err_ovf(err_ovf)
  );

  // Free-tag FIFO model, reset by the same wrst_n.
  logic [4:0] fmem [32];
  logic [5:0] fwp, frp;
  assign fifo_rempty = (fwp == frp);
  assign fifo_wfull  = (fwp[5] != frp[5]) && (fwp[4:0] == frp[4:0]);
  assign fifo_rdata  = fmem[frp[4:0]];

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      fwp <= '0;
      frp <= '0;
    end else begin
      if (fifo_winc && !fifo_wfull) fwp <= fwp + 6'd1;
      if (fifo_rinc && !fifo_rempty) frp <= frp + 6'd1;
    end
  end

  always @(posedge wclk) begin
    if (wrst_n && fifo_winc && !fifo_wfull) fmem[fwp[4:0]] <= fifo_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    wrst_n = 1'b0; req = 2'b00; ret_vld = 2'b00; ret_tag0 = 5'd0; ret_tag1 = 5'd0;

    // Held in reset
    repeat (2) @(negedge wclk);
    #1;
    chk("rst_winc", 32'(fifo_winc), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rinc", 32'(fifo_rinc), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_free_cnt", 32'(free_cnt), 0);
    chk("rst_err_ovf", 32'(err_ovf), 0);
    chk("rst_ret_rdy", 32'(ret_rdy), 0);

    // Seeding: tags 0..31 written on consecutive cycles
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("seed_winc", 32'(fifo_winc), 1);
      chk("seed_wdata", 32'(fifo_wdata), 32'(i));
      chk("seed_init_done", 32'(init_done), 0);
      @(negedge wclk);
    end
    #1;
    chk("init_done", 32'(init_done), 1);
    chk("init_free_cnt", 32'(free_cnt), 32);
    chk("init_winc_idle", 32'(fifo_winc), 0);
    chk("init_ret_rdy", 32'(ret_rdy), 1);

    // Round-robin between two requesters
    for (int i = 0; i < 4; i++) begin
      @(negedge wclk);
      req = 2'b11;
      #1;
      chk("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_tag", 32'(gnt_tag), 32'(i));
      chk("rr_rinc", 32'(fifo_rinc), 1);
    end
    @(negedge wclk);
    req = 2'b00;
    #1;
    chk("rr_free_cnt", 32'(free_cnt), 28);
    chk("idle_gnt", 32'(gnt), 0);

    // Drain the rest with requester 0 only
    for (int i = 0; i < 28; i++) begin
      @(negedge wclk);
      req = 2'b01;
      #1;
      chk("drain_gnt", 32'(gnt), 1);
      chk("drain_tag", 32'(gnt_tag), 32'(4 + i));
    end
    @(negedge wclk);
    #1;
    chk("empty_gnt", 32'(gnt), 0);
    chk("empty_rinc", 32'(fifo_rinc), 0);
    chk("empty_free_cnt", 32'(free_cnt), 0);

    // Dual return, then re-grant once the first tag is in the FIFO
    @(negedge wclk);
    ret_vld = 2'b11; ret_tag0 = 5'd7; ret_tag1 = 5'd9;
    #1;
    chk("ret_rdy_a", 32'(ret_rdy), 1);
    chk("ret_nobypass_gnt", 32'(gnt), 0);
    @(negedge wclk);
    ret_vld = 2'b00;
    #1;
    chk("ret_winc_7", 32'(fifo_winc), 1);
    chk("ret_wdata_7", 32'(fifo_wdata), 7);
    chk("ret_rdy_b", 32'(ret_rdy), 1);
    chk("ret_gnt_still_empty", 32'(gnt), 0);
    @(negedge wclk);
    #1;
    chk("ret_wdata_9", 32'(fifo_wdata), 9);
    chk("ret_winc_9", 32'(fifo_winc), 1);
    chk("regrant_gnt", 32'(gnt), 1);
    chk("regrant_tag7", 32'(gnt_tag), 7);
    @(negedge wclk);
    #1;
    chk("ret_winc_done", 32'(fifo_winc), 0);
    chk("regrant_tag9", 32'(gnt_tag), 9);
    @(negedge wclk);
    req = 2'b00;
    #1;
    chk("ret_free_cnt", 32'(free_cnt), 0);
    chk("ret_err_clean", 32'(err_ovf), 0);

    // Back-to-back dual returns fill the buffer; a return while not ready sets err_ovf
    @(negedge wclk);
    ret_vld = 2'b11; ret_tag0 = 5'd7; ret_tag1 = 5'd9;
    #1;
    chk("b2b_rdy_a", 32'(ret_rdy), 1);
    @(negedge wclk);
    ret_tag0 = 5'd0; ret_tag1 = 5'd1;
    #1;
    chk("b2b_rdy_b", 32'(ret_rdy), 1);
    chk("b2b_wdata_7", 32'(fifo_wdata), 7);
    @(negedge wclk);
    ret_vld = 2'b01; ret_tag0 = 5'd2;
    #1;
    chk("b2b_rdy_c", 32'(ret_rdy), 0);
    chk("b2b_err_before", 32'(err_ovf), 0);
    chk("b2b_wdata_9", 32'(fifo_wdata), 9);
    @(negedge wclk);
    ret_vld = 2'b00;
    #1;
    chk("ovf_err_set", 32'(err_ovf), 1);
    chk("b2b_wdata_0", 32'(fifo_wdata), 0);
    chk("b2b_rdy_d", 32'(ret_rdy), 1);
    @(negedge wclk);
    #1;
    chk("b2b_wdata_1", 32'(fifo_wdata), 1);
    chk("b2b_winc_1", 32'(fifo_winc), 1);
    @(negedge wclk);
    #1;
    chk("b2b_winc_done", 32'(fifo_winc), 0);
    chk("b2b_free_cnt", 32'(free_cnt), 4);
    chk("ovf_err_sticky", 32'(err_ovf), 1);

    // Reset, then reset again in the middle of seeding
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    chk("rst2_err_ovf", 32'(err_ovf), 0);
    chk("rst2_free_cnt", 32'(free_cnt), 0);
    chk("rst2_init_done", 32'(init_done), 0);
    chk("rst2_winc", 32'(fifo_winc), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("reseed_wdata", 32'(fifo_wdata), 32'(i));
      @(negedge wclk);
    end
    #1;
    chk("seed10_wdata", 32'(fifo_wdata), 10);
    wrst_n = 1'b0;
    #1;
    chk("midrst_winc", 32'(fifo_winc), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_free_cnt", 32'(free_cnt), 0);
    chk("midrst_init_done", 32'(init_done), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("restart_wdata", 32'(fifo_wdata), 32'(i));
      @(negedge wclk);
    end
    #1;
    chk("restart_init_done", 32'(init_done), 1);
    chk("restart_free_cnt", 32'(free_cnt), 32);
    chk("restart_err_ovf", 32'(err_ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
